parity_frame_receiver: RTL and testbench
========================================

Name: parity_frame_receiver

Overview:
- Serial receive end for the team's 9-bit parity-protected word: {data[7:0], parity_bit}, parity bit in the LSB.
- Sender parity rule: parity_bit = XOR(data) ^ parity_control, where 0 = even and 1 = odd.
- Deframes a start/data/parity/stop serial stream and checks parity against the selected mode.
- Delivers the data byte with valid and error flags, and keeps a saturating error count for status readout.

Parameters:
WIDTH, 8, data bits per frame; received word is WIDTH+1 bits including parity
COUNT_WIDTH, 8, width of the saturating error counter

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
bit_enable  input  1  one-cycle strobe per bit period; serial_in is sampled only when this is 1
serial_in  input  1  serial line; idles high
parity_control  input  1  0 = even, 1 = odd; latched at start-bit detection
output_word  output  WIDTH  last good-framed data byte
word_valid  output  1  one-cycle pulse: a new output_word is available
parity_error  output  1  parity result for the current output_word; qualified by word_valid and held with output_word
framing_error  output  1  one-cycle pulse: stop bit sampled low
error_count  output  COUNT_WIDTH  parity plus framing errors, saturating

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Reset has priority over every other input, including mid-frame.
- Reset values:
  - State = IDLE.
  - output_word = 0; word_valid = 0; parity_error = 0; framing_error = 0; error_count = 0.
  - Shift register and bit counter = 0.
- Frame format, one bit per bit_enable: start bit (0), then WIDTH data bits MSB first, then the parity bit, then the stop bit (1).
- Cycles with bit_enable = 0 change no state. Outputs still follow their pulse rules.
- State IDLE:
  - On bit_enable with serial_in = 0: latch parity_control, clear the bit counter, go to DATA.
  - On bit_enable with serial_in = 1: stay in IDLE.
- State DATA:
  - On each bit_enable, shift serial_in into the LSB of a (WIDTH+1)-bit shift register and increment the counter.
  - After WIDTH+1 bits (data plus parity), go to STOP.
- State STOP, on bit_enable:
  - serial_in = 1: on this edge load output_word = shreg[WIDTH:1] and parity_error = (XOR of all WIDTH+1 bits) != latched parity_control. Next cycle word_valid = 1 for exactly one cycle. Go to IDLE.
  - serial_in = 0: framing_error = 1 for one cycle. No word_valid; output_word and parity_error keep their previous values; no parity check is made. Go to BREAK.
- State BREAK: wait for bit_enable with serial_in = 1, then go to IDLE. A held-low line never starts a false frame.
- Latency: word_valid and framing_error assert in the clock cycle after the edge that samples the stop bit.
- error_count: +1 on the word_valid cycle with parity_error = 1, and +1 on each framing_error pulse. Holds at 2^COUNT_WIDTH-1. Never wraps.
- Parity and framing errors are mutually exclusive per frame, so the counter moves at most +1 per frame.
- A parity_control change mid-frame has no effect; the value latched at the start bit applies.
- A new start bit is accepted on the next bit_enable after the stop bit, so back-to-back frames need no idle gap.

Test Plan:
- Even mode (parity_control = 0), bit_enable every 4th cycle, frame 0,1,0,1,0,0,1,0,1,0,1 (data 8'hA5, parity 0, stop 1) -> one word_valid pulse, output_word = 8'hA5, parity_error = 0, error_count = 0.
- Odd mode, data 8'h07 with parity bit 0 -> output_word = 8'h07, parity_error = 0. Same data with parity bit 1 -> parity_error = 1, error_count = 1.
- Even mode, data 8'h3C, stop bit 0, line held low 3 more enables, then high -> framing_error pulse, no word_valid, output_word unchanged, error_count +1. Next valid frame 8'h12 is received correctly.
- Assert reset after 5 data bits of a frame, then send a full frame 8'hC3 -> all outputs 0 right after reset. The following frame gives output_word = 8'hC3 and no spurious pulses.
- 260 consecutive even-mode frames with a wrong parity bit -> error_count stops at 255. Then reset -> 0.
- Two back-to-back frames 8'hFF and 8'h00 (both parity 0, even mode), with parity_control toggled mid-frame -> two word_valid pulses, values 8'hFF then 8'h00, parity_error = 0 on both.

Source files
------------

// File: rtl/parity_frame_receiver.sv
// Serial receiver for a start/data/parity/stop frame, MSB first, with a
// parity check against the latched mode and a saturating error counter.
module parity_frame_receiver #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bit_enable,
  input  logic                   serial_in,
  input  logic                   parity_control,
  output logic [WIDTH-1:0]       output_word,
  output logic                   word_valid,
  output logic                   parity_error,
  output logic                   framing_error,
  output logic [COUNT_WIDTH-1:0] error_count
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_STOP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH:0]         shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   par_ctl_q, par_ctl_d;
  logic [WIDTH-1:0]       output_word_q, output_word_d;
  logic                   parity_error_q, parity_error_d;
  logic                   word_valid_q, word_valid_d;
  logic                   framing_error_q, framing_error_d;
  logic [COUNT_WIDTH-1:0] error_count_q, error_count_d;
  logic                   err_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      shreg_q         <= '0;
      cnt_q           <= '0;
      par_ctl_q       <= 1'b0;
      output_word_q   <= '0;
      parity_error_q  <= 1'b0;
      word_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      error_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      shreg_q         <= shreg_d;
      cnt_q           <= cnt_d;
      par_ctl_q       <= par_ctl_d;
      output_word_q   <= output_word_d;
      parity_error_q  <= parity_error_d;
      word_valid_q    <= word_valid_d;
      framing_error_q <= framing_error_d;
      error_count_q   <= error_count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    shreg_d         = shreg_q;
    cnt_d           = cnt_q;
    par_ctl_d       = par_ctl_q;
    output_word_d   = output_word_q;
    parity_error_d  = parity_error_q;
    word_valid_d    = 1'b0;
    framing_error_d = 1'b0;
    error_count_d   = error_count_q;

    // Errors are counted on the pulse cycle, so at most one step per frame.
    err_inc = (word_valid_q && parity_error_q) || framing_error_q;
    if (err_inc && (error_count_q != {COUNT_WIDTH{1'b1}}))
      error_count_d = error_count_q + COUNT_WIDTH'(1);

    if (bit_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (!serial_in) begin
            par_ctl_d = parity_control;
            cnt_d     = '0;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          shreg_d = {shreg_q[WIDTH-1:0], serial_in};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH)) state_d = ST_STOP;
        end
        ST_STOP: begin
          if (serial_in) begin
            output_word_d  = shreg_q[WIDTH:1];
            parity_error_d = (^shreg_q) != par_ctl_q;
            word_valid_d   = 1'b1;
            state_d        = ST_IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = ST_BREAK;
          end
        end
        ST_BREAK: begin
          // A line stuck low must return high before a new start bit counts.
          if (serial_in) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign output_word   = output_word_q;
  assign word_valid    = word_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign error_count   = error_count_q;

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Directed bench for parity_frame_receiver: frames sent with a bit strobe
// every 4th clock; received words are scored against an expected queue.
module tb_parity_frame_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_enable = 1'b0;
  logic       serial_in = 1'b1;
  logic       parity_control = 1'b0;
  logic [7:0] output_word;
  logic       word_valid;
  logic       parity_error;
  logic       framing_error;
  logic [7:0] error_count;

  int checks = 0;
  int errors = 0;
  int wv_cnt = 0;
  int fe_cnt = 0;
  int wv_base;
  int fe_base;
  logic [8:0] exp_q[$];  // {parity_error, data}

  parity_frame_receiver #(.WIDTH(8), .COUNT_WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .bit_enable    (bit_enable),
    .serial_in     (serial_in),
    .parity_control(parity_control),
    .output_word   (output_word),
    .word_valid    (word_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .error_count   (error_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every word_valid pulse must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && word_valid) begin
      wv_cnt++;
      if (exp_q.size() == 0) begin
        check("wv_unexpected", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("word", {24'd0, output_word}, {24'd0, e[7:0]});
        check("perr", {31'd0, parity_error}, {31'd0, e[8]});
      end
    end
    if (!reset && framing_error) fe_cnt++;
  end

  // driver tasks
  task automatic send_bit(input logic b);
    repeat (3) @(posedge clk);
    #1 bit_enable = 1'b1;
    serial_in = b;
    @(posedge clk);
    #1 bit_enable = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(data[i]);
    send_bit(pbit);
    send_bit(stop);
    @(negedge clk);
    if (stop) check("wv_latency", {31'd0, word_valid}, 32'd1);
    else      check("fe_latency", {31'd0, framing_error}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    bit_enable = 1'b0;
    serial_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_word", {24'd0, output_word}, 32'd0);
    check("rst_wv", {31'd0, word_valid}, 32'd0);
    check("rst_perr", {31'd0, parity_error}, 32'd0);
    check("rst_fe", {31'd0, framing_error}, 32'd0);
    check("rst_cnt", {24'd0, error_count}, 32'd0);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    do_reset();

    // even mode, 8'hA5, parity 0
    parity_control = 1'b0;
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b0, 1'b1);
    settle();
    check("a5_wv_count", wv_cnt, 1);
    check("a5_cnt", {24'd0, error_count}, 32'd0);

    // odd mode, 8'h07 good then bad parity
    parity_control = 1'b1;
    exp_q.push_back({1'b0, 8'h07});
    send_frame(8'h07, 1'b0, 1'b1);
    exp_q.push_back({1'b1, 8'h07});
    send_frame(8'h07, 1'b1, 1'b1);
    settle();
    check("odd_wv_count", wv_cnt, 3);
    check("odd_cnt", {24'd0, error_count}, 32'd1);

    // framing error with held-low line, then recovery
    parity_control = 1'b0;
    wv_base = wv_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (3) send_bit(1'b0);
    send_bit(1'b1);
    settle();
    check("fe_count", fe_cnt, 1);
    check("fe_no_wv", wv_cnt, wv_base);
    check("fe_word_held", {24'd0, output_word}, 32'h07);
    check("fe_perr_held", {31'd0, parity_error}, 32'd1);
    check("fe_cnt", {24'd0, error_count}, 32'd2);
    exp_q.push_back({1'b0, 8'h12});
    send_frame(8'h12, 1'b0, 1'b1);
    settle();
    check("rec_cnt", {24'd0, error_count}, 32'd2);

    // reset mid-frame, then a clean frame
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    do_reset();
    wv_base = wv_cnt;
    fe_base = fe_cnt;
    exp_q.push_back({1'b0, 8'hC3});
    send_frame(8'hC3, 1'b0, 1'b1);
    settle();
    check("c3_wv_count", wv_cnt, wv_base + 1);
    check("c3_fe_count", fe_cnt, fe_base);
    check("c3_cnt", {24'd0, error_count}, 32'd0);

    // saturation: 260 bad-parity frames
    for (int n = 0; n < 260; n++) begin
      exp_q.push_back({1'b1, 8'h00});
      send_frame(8'h00, 1'b1, 1'b1);
      if (n == 253) begin
        settle();
        check("sat_254", {24'd0, error_count}, 32'd254);
      end
    end
    settle();
    check("sat_255", {24'd0, error_count}, 32'd255);
    do_reset();

    // back-to-back frames with parity_control toggled mid-frame
    wv_base = wv_cnt;
    for (int f = 0; f < 2; f++) begin
      logic [7:0] d;
      d = (f == 0) ? 8'hFF : 8'h00;
      exp_q.push_back({1'b0, d});
      send_bit(1'b0);
      for (int i = 7; i >= 0; i--) begin
        send_bit(d[i]);
        if (i == 4) parity_control = 1'b1;
      end
      send_bit(1'b0);
      parity_control = 1'b0;
      send_bit(1'b1);
    end
    settle();
    check("b2b_wv_count", wv_cnt, wv_base + 2);
    check("b2b_cnt", {24'd0, error_count}, 32'd0);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
